// File: rtl/apb_periph_pkg.sv
// Shared types and constants for the APB peripheral completer.
// Register offsets are byte offsets inside the register window.
package apb_periph_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int WAIT_W = 4;

    localparam logic [31:0] REG_WIN_BASE = 32'h0000_1000;
    localparam logic [31:0] ID_VALUE     = 32'hA735_0002;

    localparam logic [4:0] OFF_LED      = 5'h00;
    localparam logic [4:0] OFF_RGB      = 5'h04;
    localparam logic [4:0] OFF_INPUTS   = 5'h08;
    localparam logic [4:0] OFF_ID       = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH  = 5'h10;
    localparam logic [4:0] OFF_IRQ_STAT = 5'h14;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h18;
    localparam logic [4:0] OFF_WAIT     = 5'h1C;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_input_sync.sv
// Two-flop synchroniser for asynchronous board inputs, followed by a
// previous-value register so any bit change shows up on `change`.
module apb_input_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] change
);

    logic [W-1:0] s1;
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            s1   <= din;
            sync <= s1;
            prev <= sync;
        end
    end

    assign change = sync ^ prev;

endmodule

// File: rtl/apb_periph_slave.sv
// APB4 completer: SRAM window, board-I/O register bank with input-change
// interrupts, and a runtime wait-state register.
module apb_periph_slave
    import apb_periph_pkg::*;
#(
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             DEPTH     = 256,
    parameter int             NLED      = 4,
    parameter int             NIN       = 8,
    parameter logic [AW-1:0]  BASE_ADDR = 32'h4000_0000,
    parameter int             WAIT_RST  = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [AW-1:0]     PADDR,
    input  logic [2:0]        PPROT,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DW-1:0]     PWDATA,
    input  logic [DW/8-1:0]   PSTRB,
    output logic [DW-1:0]     PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NLED-1:0]   leds,
    output logic [5:0]        rgb_leds,
    input  logic [NIN-1:0]    inputs,
    output logic              irq
);

    localparam int            AIW        = $clog2(DEPTH);
    localparam logic [AW-1:0] SRAM_BYTES = AW'(DEPTH * 4);
    localparam logic [AW-1:0] REG_BASE   = AW'(REG_WIN_BASE);

    apb_state_t          state, nxt;
    logic [WAIT_W-1:0]   wcnt, wait_reg;
    logic [AW-1:0]       offset;
    logic [4:0]          roff;
    logic [AIW-1:0]      widx;
    logic                in_sram, in_reg, err;
    logic                pready, commit, sram_we, reg_we;
    logic [31:0]         rdata, bmask, wmerge, scratch;
    logic [31:0]         mem [DEPTH];
    logic [NIN-1:0]      in_sync, in_change, irq_stat, irq_en, clr;
    logic                unused;

    assign unused = ^PPROT[2:1];

    apb_input_sync #(.W(NIN)) u_sync (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .din    (inputs),
        .sync   (in_sync),
        .change (in_change)
    );

    assign offset  = PADDR - BASE_ADDR;
    assign roff    = offset[4:0];
    assign widx    = offset[AIW+1:2];
    assign in_sram = offset < SRAM_BYTES;
    assign in_reg  = offset[AW-1:5] == REG_BASE[AW-1:5];

    // IRQ_STAT, IRQ_EN and WAIT are the privileged tail of the bank.
    assign err = (PADDR[1:0] != 2'b00)
               || !(in_sram || in_reg)
               || (in_reg && PWRITE
                   && (roff == OFF_INPUTS || roff == OFF_ID))
               || (in_reg && roff >= OFF_IRQ_STAT && !PPROT[0]);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (PSEL && !PENABLE) nxt = SETUP;
            SETUP:   if (PSEL && PENABLE)  nxt = ACCESS;
            ACCESS:  if (pready)
                         nxt = (PSEL && !PENABLE) ? SETUP : IDLE;
            default: nxt = IDLE;
        endcase
        if (!PSEL) nxt = IDLE;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            if (nxt == SETUP && state != SETUP) wcnt <= wait_reg;
            else if (state == ACCESS && wcnt != '0) wcnt <= wcnt - 1'b1;
        end
    end

    assign pready  = (state == ACCESS) && (wcnt == '0);
    assign commit  = PSEL && PENABLE && pready && !err;
    assign sram_we = commit && PWRITE && in_sram;
    assign reg_we  = commit && PWRITE && in_reg;

    always_comb begin
        rdata = '0;
        if (in_sram) begin
            rdata = mem[widx];
        end else begin
            unique case (roff)
                OFF_LED:      rdata = 32'(leds);
                OFF_RGB:      rdata = 32'(rgb_leds);
                OFF_INPUTS:   rdata = 32'(in_sync);
                OFF_ID:       rdata = ID_VALUE;
                OFF_SCRATCH:  rdata = scratch;
                OFF_IRQ_STAT: rdata = 32'(irq_stat);
                OFF_IRQ_EN:   rdata = 32'(irq_en);
                OFF_WAIT:     rdata = 32'(wait_reg);
                default:      rdata = '0;
            endcase
        end
    end

    // Strobed writes merge into the current contents of the target.
    assign bmask  = byte_mask(PSTRB);
    assign wmerge = (rdata & ~bmask) | (PWDATA & bmask);
    assign clr    = (reg_we && roff == OFF_IRQ_STAT)
                  ? (PWDATA[NIN-1:0] & bmask[NIN-1:0]) : '0;

    always_ff @(posedge PCLK) begin
        if (sram_we) mem[widx] <= wmerge;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            leds     <= '0;
            rgb_leds <= '0;
            scratch  <= '0;
            irq_en   <= '0;
            wait_reg <= WAIT_W'(WAIT_RST);
            irq_stat <= '0;
            irq      <= 1'b0;
        end else begin
            if (reg_we) begin
                unique case (roff)
                    OFF_LED:     leds     <= wmerge[NLED-1:0];
                    OFF_RGB:     rgb_leds <= wmerge[5:0];
                    OFF_SCRATCH: scratch  <= wmerge;
                    OFF_IRQ_EN:  irq_en   <= wmerge[NIN-1:0];
                    OFF_WAIT:    wait_reg <= wmerge[WAIT_W-1:0];
                    default:     ;
                endcase
            end
            // A new edge overrides a clear on the same bit.
            irq_stat <= (irq_stat & ~clr) | in_change;
            irq      <= |(irq_stat & irq_en);
        end
    end

    assign PREADY  = pready;
    assign PSLVERR = pready && err;
    assign PRDATA  = (pready && !err) ? rdata : '0;

endmodule

// File: tb/tb_apb_periph_slave.sv
// Scoreboard bench for apb_periph_slave: the driver queues expected
// responses, a negedge monitor pops them on every completed transfer.
module tb_apb_periph_slave;
    import apb_periph_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic [2:0]  PPROT;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [3:0]  leds;
    logic [5:0]  rgb_leds;
    logic [7:0]  inputs;
    logic        irq;

    apb_periph_slave dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PADDR    (PADDR),
        .PPROT    (PPROT),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .leds     (leds),
        .rgb_leds (rgb_leds),
        .inputs   (inputs),
        .irq      (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   acc    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // acc counts bus access-phase cycles up to and including PREADY:
    // WAIT=0 completes on the 2nd, WAIT=N on the (2+N)th.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESETn) begin
            acc = 0;
        end else if (PSEL && PENABLE) begin
            acc++;
            if (PREADY) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_ready: got PREADY=1 expected none");
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_err"}, 32'(PSLVERR), 32'(e.err));
                    if (e.chk_data) chk({e.name, "_data"}, PRDATA, e.data);
                    chk({e.name, "_lat"}, acc, e.lat);
                end
                acc = 0;
            end
        end else begin
            acc = 0;
        end
    end

    task automatic setup_access(input logic wr, input logic [31:0] off,
                                input logic [31:0] wd, input logic [3:0] st,
                                input logic [2:0] pr);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = BASE + off; PWDATA = wd; PSTRB = st; PPROT = pr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 64);
        if (!PREADY) begin
            n_chk++;
            $display("FAIL %s_timeout: got no PREADY expected PREADY within 64", nm);
        end
    endtask

    task automatic xfer(input string nm, input logic wr,
                        input logic [31:0] off, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr,
                        input logic [31:0] ed, input logic cd,
                        input logic ee, input int lat);
        q.push_back('{ed, cd, ee, lat, nm});
        setup_access(wr, off, wd, st, pr);
        wait_ready(nm);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [31:0] off,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input logic ee, input int lat);
        xfer(nm, 1'b1, off, wd, st, pr, 32'h0, ee, ee, lat);
    endtask

    task automatic rd(input string nm, input logic [31:0] off,
                      input logic [2:0] pr, input logic [31:0] ed,
                      input logic ee, input int lat);
        xfer(nm, 1'b0, off, 32'h0, 4'h0, pr, ed, 1'b1, ee, lat);
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; inputs = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_rgb", 32'(rgb_leds), 32'h0);
        PRESETn = 1'b1;

        // SRAM byte strobes, WAIT=0
        wr("sram_clr", 32'h40, 32'h0, 4'hF, 3'd0, 1'b0, 2);
        wr("sram_part", 32'h40, 32'hDEADBEEF, 4'b0101, 3'd0, 1'b0, 2);
        rd("sram_rd", 32'h40, 3'd0, 32'h00AD00EF, 1'b0, 2);

        // WAIT=3 applies from the next SETUP
        wr("wait3", 32'h101C, 32'h3, 4'hF, 3'd1, 1'b0, 2);
        rd("id_rd", 32'h100C, 3'd0, 32'hA735_0002, 1'b0, 5);
        rd("wait_rd", 32'h101C, 3'd1, 32'h3, 1'b0, 5);

        // error responses, no side effects
        rd("err_range", 32'h2000, 3'd1, 32'h0, 1'b1, 5);
        wr("err_ro", 32'h1008, 32'hFF, 4'hF, 3'd1, 1'b1, 5);
        wr("err_unal", 32'h41, 32'hFFFFFFFF, 4'hF, 3'd1, 1'b1, 5);
        wr("err_prot", 32'h1018, 32'hFF, 4'hF, 3'd0, 1'b1, 5);
        rd("sram_keep", 32'h40, 3'd0, 32'h00AD00EF, 1'b0, 5);
        rd("irqen_keep", 32'h1018, 3'd1, 32'h0, 1'b0, 5);
        wr("wait0", 32'h101C, 32'h0, 4'h1, 3'd1, 1'b0, 5);

        // plain registers with strobes
        wr("led_wr", 32'h1000, 32'hFF, 4'h1, 3'd0, 1'b0, 2);
        chk("leds_pin", 32'(leds), 32'hF);
        rd("led_rd", 32'h1000, 3'd0, 32'hF, 1'b0, 2);
        wr("rgb_nostrb", 32'h1004, 32'hFFFFFFFF, 4'b1110, 3'd0, 1'b0, 2);
        rd("rgb_rd0", 32'h1004, 3'd0, 32'h0, 1'b0, 2);
        wr("rgb_wr", 32'h1004, 32'h2A, 4'h1, 3'd0, 1'b0, 2);
        chk("rgb_pin", 32'(rgb_leds), 32'h2A);
        wr("scr_wr", 32'h1010, 32'h12345678, 4'b1100, 3'd0, 1'b0, 2);
        rd("scr_rd", 32'h1010, 3'd0, 32'h12340000, 1'b0, 2);

        // input-change interrupt
        wr("irqen_wr", 32'h1018, 32'h1, 4'hF, 3'd1, 1'b0, 2);
        @(posedge PCLK); #1;
        inputs[0] = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("irq_c3", 32'(irq), 32'h0);
        @(posedge PCLK); #1;
        chk("irq_c4", 32'(irq), 32'h1);
        rd("stat_rd", 32'h1014, 3'd1, 32'h1, 1'b0, 2);
        rd("inputs_rd", 32'h1008, 3'd0, 32'h1, 1'b0, 2);
        wr("w1c_nostrb", 32'h1014, 32'h1, 4'h0, 3'd1, 1'b0, 2);
        rd("stat_keep", 32'h1014, 3'd1, 32'h1, 1'b0, 2);
        wr("w1c", 32'h1014, 32'h1, 4'h1, 3'd1, 1'b0, 2);
        chk("irq_hold", 32'(irq), 32'h1);
        @(posedge PCLK); #1;
        chk("irq_clr", 32'(irq), 32'h0);

        // abort a WAIT=5 LED write mid-wait
        wr("wait5", 32'h101C, 32'h5, 4'hF, 3'd1, 1'b0, 2);
        setup_access(1'b1, 32'h1000, 32'h5, 4'hF, 3'd0);
        repeat (3) @(negedge PCLK);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_leds", 32'(leds), 32'hF);
        rd("abort_rd", 32'h1000, 3'd0, 32'hF, 1'b0, 7);

        // reset during ACCESS with PREADY high and irq pending
        wr("sram80", 32'h80, 32'h11111111, 4'hF, 3'd0, 1'b0, 7);
        @(posedge PCLK); #1;
        inputs[0] = 1'b0;
        repeat (5) @(posedge PCLK);
        #1;
        chk("irq_pre_rst", 32'(irq), 32'h1);
        q.push_back('{32'h0, 1'b0, 1'b0, 7, "rst_xfer"});
        setup_access(1'b1, 32'h80, 32'h22222222, 4'hF, 3'd0);
        wait_ready("rst_xfer");
        #1;
        PRESETn = 1'b0;
        #1;
        chk("rst_mid_pready", 32'(PREADY), 32'h0);
        chk("rst_mid_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_mid_irq", 32'(irq), 32'h0);
        chk("rst_mid_leds", 32'(leds), 32'h0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        rd("wait_rst", 32'h101C, 3'd1, 32'h0, 1'b0, 2);
        rd("sram_nowr", 32'h80, 3'd0, 32'h11111111, 1'b0, 2);

        repeat (2) @(posedge PCLK);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_periph_slave.md
# apb_periph_slave

Parametrised APB4 completer combining a word-addressed SRAM window, a board-I/O register bank with input-change interrupts, and programmable wait states. Generational successor to the single-window APB slave: adds PSTRB on all writable storage, PPROT-based register protection, unaligned/out-of-range error decoding, synchronised input edge detection with a maskable `irq`, and a runtime wait-state register. It sits on the SoC APB segment behind the APB bridge and drives the Arty A7 LEDs directly.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width; fixed at 32 for the register bank.
- `DEPTH`, 256, SRAM words; power of two, at most 1024.
- `NLED`, 4, plain LED count.
- `NIN`, 8, synchronised input bits, `{buttons, switches}`.
- `BASE_ADDR`, 32'h4000_0000, block base address.
- `WAIT_RST`, 0, reset value of the WAIT register, 0–15.
- `PCLK`  in  1  clock.
- `PRESETn`  in  1  reset: PRESETn, asynchronous, active-low; clock PCLK.
- `PADDR`  in  AW  byte address.
- `PPROT`  in  3  protection; bit0 set means privileged.
- `PSEL`, `PENABLE`, `PWRITE`  in  1 each  APB controls.
- `PWDATA`  in  DW  write data.
- `PSTRB`  in  DW/8  byte write strobes.
- `PRDATA`  out  DW  read data.
- `PREADY`  out  1  transfer complete.
- `PSLVERR`  out  1  error response.
- `leds`  out  NLED  LED drive.
- `rgb_leds`  out  6  RGB drive.
- `inputs`  in  NIN  asynchronous board inputs.
- `irq`  out  1  level interrupt, registered.

## Operation
- Offset = `PADDR - BASE_ADDR`.
- Offsets 0x0000 to `DEPTH*4-1`: SRAM.
- Offsets 0x1000 to 0x101F: register bank.
  - 0x00 LED: RW, bits [NLED-1:0].
  - 0x04 RGB: RW, bits [5:0].
  - 0x08 INPUTS: RO, synchronised `inputs`.
  - 0x0C ID: RO, 32'hA735_0002.
  - 0x10 SCRATCH: RW, 32 bits.
  - 0x14 IRQ_STAT: W1C, bits [NIN-1:0].
  - 0x18 IRQ_EN: RW, bits [NIN-1:0].
  - 0x1C WAIT: RW, bits [3:0].
- Bits above the implemented width read as 0 and ignore writes.
- PSTRB applies to SRAM and to every RW register. On W1C, a clear needs both the strobe and the data bit set.
- PSLVERR=1 in any of these cases:
  - offset is outside both windows;
  - `PADDR[1:0]!=0`;
  - write to INPUTS or ID;
  - any access to 0x1014–0x101C with `PPROT[0]=0`.
- An errored transfer has no side effects and returns PRDATA=0.
- Inputs pass through a 2-flop synchroniser, then a previous-value register. Any bit change sets the matching IRQ_STAT bit.
- `irq` is the registered OR-reduction of `IRQ_STAT & IRQ_EN`.
- FSM, enum in package:
  - IDLE→SETUP on PSEL && !PENABLE.
  - SETUP→ACCESS on PSEL && PENABLE.
  - ACCESS→SETUP on PREADY && PSEL && !PENABLE (back-to-back).
  - ACCESS→IDLE on PREADY otherwise.
  - Any state→IDLE on !PSEL (abort).
- Wait counter: loaded from WAIT on entering SETUP, decrements in ACCESS while non-zero.

## Timing
- Reset values:
  - PRDATA 0, PREADY 0, PSLVERR 0, irq 0.
  - leds 0, rgb_leds 0, SCRATCH 0, IRQ_STAT 0, IRQ_EN 0.
  - WAIT = WAIT_RST; synchroniser and previous-value registers 0.
  - SRAM not reset.
- PREADY = (state==ACCESS) && (wcnt==0), combinational. Latency: WAIT=0 completes in the first ACCESS cycle; WAIT=N adds N cycles.
- PRDATA and PSLVERR are valid only while PREADY=1, otherwise 0. SRAM is read combinationally.
- Writes commit on the PCLK edge where PSEL && PENABLE && PREADY && !PSLVERR.
- A WAIT write takes effect from the next SETUP.
- Input change to IRQ_STAT set: 3 cycles. IRQ_STAT to `irq`: 1 further cycle.
- If a W1C clear and a new edge hit the same bit in one cycle, set wins.
- PSEL deasserted mid-wait: no commit, IDLE next cycle, counter discarded.
- Reset asserted mid-transfer: all outputs return to reset values immediately; no partial write.

## Structure
- Package `apb_periph_pkg` holds:
  - `apb_state_t` (IDLE, SETUP, ACCESS);
  - register offset localparams;
  - REG_WIN_BASE=0x1000;
  - ID constant;
  - WAIT field width.
- Sub-module `apb_input_sync #(W)`: 2-flop synchroniser plus edge detect; outputs `sync[W-1:0]` and `change[W-1:0]`.

## Test plan
- WAIT=0; write 0xDEADBEEF to BASE+0x40 with PSTRB=4'b0101, then read it. Required: 0x00AD00EF, PREADY in the first ACCESS cycle, PSLVERR=0.
- Write 3 to WAIT with PPROT=1, then read ID. Required: PREADY asserts 3 cycles after ACCESS entry, PRDATA=0xA735_0002.
- Each of the following returns PSLVERR=1, PRDATA=0 and leaves state unchanged:
  - read of BASE+0x2000;
  - write to BASE+0x1008;
  - write to BASE+0x41;
  - write to IRQ_EN with PPROT=0.
- Set IRQ_EN=0x01 and toggle `inputs[0]`. Required: IRQ_STAT=0x01 and `irq`=1 within 4 cycles; after writing 0x01 to IRQ_STAT, `irq`=0 one cycle later.
- Drop PSEL during a WAIT=5 write to LED. Required: LED unchanged, FSM returns to IDLE.
- Assert PRESETn low during ACCESS. Required: PREADY, PSLVERR and irq at 0 in the same cycle; WAIT reads back WAIT_RST after release.
